// File: rtl/bcd_count_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_count_ctrl
//
// Single-clock sequencer for a 4-digit BCD counter feeding a multiplexed
// 7-segment display. A prescaler produces a one-cycle tick enable while the
// counter is running, and all four digits are updated together on that tick
// through a same-cycle carry/borrow chain (no ripple clocks). A small FSM
// accepts start/stop/load commands, and a free-running scan counter selects
// which digit is presented to the external BCD-to-segment converter.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   start      single-cycle start/resume command
//   stop       single-cycle pause command
//   load       single-cycle load command (all digits <= data_in, clamped to 9)
//   data_in    BCD value loaded into all four digits
//   up_dn      1 = count up, 0 = count down; sampled on each tick
//   ones       BCD digit 0
//   tens       BCD digit 1
//   hundreds   BCD digit 2
//   thousands  BCD digit 3
//   anode      active-low one-hot digit enable; 4'b1111 = blanked
//   digit      BCD value of the currently selected digit
//   running    high while the FSM is in RUN
//   tc         one-cycle pulse following a terminal-count tick
// ---------------------------------------------------------------------------
module bcd_count_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000,
    parameter int WRAP     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       load,
    input  logic [3:0] data_in,
    input  logic       up_dn,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic [3:0] thousands,
    output logic [3:0] anode,
    output logic [3:0] digit,
    output logic       running,
    output logic       tc
);

    localparam int PRE_W  = $clog2(TICK_DIV);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } state_t;

    state_t              state;
    logic [PRE_W-1:0]    presc;
    logic [3:0][3:0]     digs;
    logic [3:0][3:0]     stepped;
    logic                terminal;
    logic                tick;
    logic [3:0]          load_val;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [1:0]          sel;
    logic                blank;

    // The tick fires on the last prescaler count while running. Loaded values
    // above 9 are not valid BCD, so they are clamped to 9 before storage.
    assign tick     = (state == RUN) && (presc == PRE_LAST);
    assign load_val = (data_in > 4'd9) ? 4'd9 : data_in;

    // Carry/borrow chain across all four digits evaluated in one cycle. The
    // chain enters digit 0 as a constant 1 (the tick itself); a digit passes
    // it on only when it wraps (9->0 up, 0->9 down). If the chain survives
    // past the top digit every digit wrapped, which is exactly the terminal
    // count (9999 up or 0000 down), and the stepped value is already the
    // rolled-over value.
    always_comb begin
        logic carry;
        stepped = digs;
        carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (up_dn) begin
                    if (digs[i] == 4'd9) begin
                        stepped[i] = 4'd0;
                        carry      = 1'b1;
                    end else begin
                        stepped[i] = digs[i] + 4'd1;
                        carry      = 1'b0;
                    end
                end else begin
                    if (digs[i] == 4'd0) begin
                        stepped[i] = 4'd9;
                        carry      = 1'b1;
                    end else begin
                        stepped[i] = digs[i] - 4'd1;
                        carry      = 1'b0;
                    end
                end
            end
        end
        terminal = carry;
    end

    // Command FSM, prescaler, digit registers and the terminal-count pulse.
    // In RUN only stop matters; a terminal tick without wrap wins over stop
    // and parks the counter in DONE with its digits held. A stop landing on a
    // tick still applies that tick's update. Outside RUN, load beats start,
    // and start is refused in DONE. The prescaler restarts from 0 each time
    // RUN is entered so the first tick is a full TICK_DIV cycles away.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            digs  <= '0;
            presc <= '0;
            tc    <= 1'b0;
        end else begin
            tc <= tick && terminal;
            case (state)
                RUN: begin
                    presc <= tick ? '0 : presc + 1'b1;
                    if (tick && terminal && (WRAP == 0)) begin
                        state <= DONE;
                    end else begin
                        if (tick) begin
                            digs <= stepped;
                        end
                        if (stop) begin
                            state <= PAUSED;
                        end
                    end
                end
                default: begin
                    if (load) begin
                        digs  <= {4{load_val}};
                        state <= PAUSED;
                    end else if (start && (state != DONE)) begin
                        state <= RUN;
                        presc <= '0;
                    end
                end
            endcase
        end
    end

    // Display scan timing runs in every state, independent of the FSM, so
    // the display keeps refreshing while idle, paused or done.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            sel      <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            sel      <= sel + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Digit mux and leading-zero blanking. An upper digit is dark when it and
    // every digit above it are zero; the ones digit is always lit. The digit
    // value is still reported while the anode is blanked.
    always_comb begin
        digit = digs[sel];
        blank = 1'b0;
        case (sel)
            2'd1:    blank = (digs[3] == 4'd0) && (digs[2] == 4'd0) && (digs[1] == 4'd0);
            2'd2:    blank = (digs[3] == 4'd0) && (digs[2] == 4'd0);
            2'd3:    blank = (digs[3] == 4'd0);
            default: blank = 1'b0;
        endcase
        anode = blank ? 4'b1111 : ~(4'b0001 << sel);
    end

    assign ones      = digs[0];
    assign tens      = digs[1];
    assign hundreds  = digs[2];
    assign thousands = digs[3];
    assign running   = (state == RUN);

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_count_ctrl
//
// Drives two copies of bcd_count_ctrl from the same stimulus: one that rolls
// over at terminal count and one that stops in DONE. Directed scenarios check
// against fixed expected values, and a randomized run checks every cycle
// against an integer-valued reference model of the counter and display.
// ---------------------------------------------------------------------------
module tb_bcd_count_ctrl;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_PAUSED = 2;
    localparam int S_DONE   = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       load;
    logic [3:0] data_in;
    logic       up_dn;

    logic [3:0] ones_w, tens_w, hund_w, thou_w, anode_w, digit_w;
    logic       running_w, tc_w;
    logic [3:0] ones_h, tens_h, hund_h, thou_h, anode_h, digit_h;
    logic       running_h, tc_h;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: index 0 tracks the wrapping copy, 1 the
    // stop-in-DONE copy. The count is kept as a plain integer 0..9999.
    int m_val[2];
    int m_st[2];
    int m_el[2];
    bit m_tc[2];
    int m_scan;
    int m_sel;

    bcd_count_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .WRAP(1)) dut_wrap (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
        .data_in(data_in), .up_dn(up_dn),
        .ones(ones_w), .tens(tens_w), .hundreds(hund_w), .thousands(thou_w),
        .anode(anode_w), .digit(digit_w), .running(running_w), .tc(tc_w)
    );

    bcd_count_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .WRAP(0)) dut_hold (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
        .data_in(data_in), .up_dn(up_dn),
        .ones(ones_h), .tens(tens_h), .hundreds(hund_h), .thousands(thou_h),
        .anode(anode_h), .digit(digit_h), .running(running_h), .tc(tc_h)
    );

    always #5 clk = ~clk;

    // Behavioural model advanced on every rising edge. Inputs only change on
    // falling edges, so they are stable here.
    always @(posedge clk) begin
        int nst;
        bit tk;
        bit term;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_val[k] = 0;
                m_st[k]  = S_IDLE;
                m_el[k]  = 0;
                m_tc[k]  = 1'b0;
            end else begin
                m_tc[k] = 1'b0;
                nst     = m_st[k];
                if (m_st[k] == S_RUN) begin
                    tk = ((m_el[k] % TICK_DIV) == TICK_DIV - 1);
                    m_el[k] = m_el[k] + 1;
                    if (tk) begin
                        term = up_dn ? (m_val[k] == 9999) : (m_val[k] == 0);
                        if (term) m_tc[k] = 1'b1;
                        if (term && k == 1) nst = S_DONE;
                        else m_val[k] = up_dn ? (m_val[k] + 1) % 10000 : (m_val[k] + 9999) % 10000;
                    end
                    if (stop && nst == S_RUN) nst = S_PAUSED;
                end else if (load) begin
                    m_val[k] = ((data_in > 4'd9) ? 9 : int'(data_in)) * 1111;
                    nst = S_PAUSED;
                end else if (start && m_st[k] != S_DONE) begin
                    nst = S_RUN;
                    m_el[k] = 0;
                end
                m_st[k] = nst;
            end
        end
        if (reset) begin
            m_scan = 0;
            m_sel  = 0;
        end else if (m_scan == SCAN_DIV - 1) begin
            m_scan = 0;
            m_sel  = (m_sel + 1) % 4;
        end else begin
            m_scan = m_scan + 1;
        end
    end

    // Expected output bundle {thousands,hundreds,tens,ones,anode,digit,running,tc}
    // derived from the model's integer count and scan position.
    function automatic logic [25:0] model_out(input int k);
        int pw[4];
        logic [3:0] d[4];
        logic [3:0] an;
        pw[0] = 1; pw[1] = 10; pw[2] = 100; pw[3] = 1000;
        for (int i = 0; i < 4; i++) d[i] = 4'((m_val[k] / pw[i]) % 10);
        if (m_sel > 0 && (m_val[k] / pw[m_sel]) == 0) an = 4'b1111;
        else an = ~(4'b0001 << m_sel);
        return {d[3], d[2], d[1], d[0], an, d[m_sel], (m_st[k] == S_RUN), m_tc[k]};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_cmd(input bit s, input bit p, input bit l, input logic [3:0] d);
        start   = s;
        stop    = p;
        load    = l;
        data_in = d;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        load  = 1'b0;
    endtask

    // Reset values, then the idle scan pattern with upper digits blanked.
    task automatic test_reset();
        logic [3:0] exp_an;
        apply_reset();
        n_tests++;
        if ({thou_w, hund_w, tens_w, ones_w} !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL reset_digits: got %h expected 0000", {thou_w, hund_w, tens_w, ones_w});
        end
        n_tests++;
        if ({running_w, tc_w, anode_w, digit_w} !== {1'b0, 1'b0, 4'b1110, 4'h0}) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got run=%b tc=%b anode=%b digit=%h expected 0 0 1110 0",
                     running_w, tc_w, anode_w, digit_w);
        end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cycles(1);
            exp_an = ((k / 2) % 4 == 0) ? 4'b1110 : 4'b1111;
            n_tests++;
            if (anode_w !== exp_an) begin
                n_fail++;
                $display("[TB] FAIL reset_scan k=%0d: got %b expected %b", k, anode_w, exp_an);
            end
        end
    endtask

    // Start and the first-tick latency.
    task automatic test_start_latency();
        apply_reset();
        up_dn = 1'b1;
        do_cmd(1, 0, 0, 4'h0);
        n_tests++;
        if (running_w !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL start_running: got %b expected 1", running_w);
        end
        cycles(3);
        n_tests++;
        if (ones_w !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL early_tick: got %h expected 0", ones_w);
        end
        cycles(1);
        n_tests++;
        if (ones_w !== 4'd1) begin
            n_fail++;
            $display("[TB] FAIL first_tick: got %h expected 1", ones_w);
        end
        cycles(4);
        n_tests++;
        if (ones_w !== 4'd2) begin
            n_fail++;
            $display("[TB] FAIL second_tick: got %h expected 2", ones_w);
        end
    endtask

    // Up-count terminal count in both wrap modes.
    task automatic test_terminal_up();
        apply_reset();
        up_dn = 1'b1;
        do_cmd(0, 0, 1, 4'd9);
        n_tests++;
        if ({thou_h, hund_h, tens_h, ones_h, running_h} !== {16'h9999, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL load9: got %h run=%b expected 9999 0", {thou_h, hund_h, tens_h, ones_h}, running_h);
        end
        do_cmd(1, 0, 0, 4'd0);
        cycles(3);
        n_tests++;
        if ({thou_w, hund_w, tens_w, ones_w, tc_w} !== {16'h9999, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL pre_tc: got %h tc=%b expected 9999 0", {thou_w, hund_w, tens_w, ones_w}, tc_w);
        end
        cycles(1);
        n_tests++;
        if ({thou_w, hund_w, tens_w, ones_w, tc_w, running_w} !== {16'h0000, 1'b1, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL wrap_up: got %h tc=%b run=%b expected 0000 1 1",
                     {thou_w, hund_w, tens_w, ones_w}, tc_w, running_w);
        end
        n_tests++;
        if ({thou_h, hund_h, tens_h, ones_h, tc_h, running_h} !== {16'h9999, 1'b1, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL hold_up: got %h tc=%b run=%b expected 9999 1 0",
                     {thou_h, hund_h, tens_h, ones_h}, tc_h, running_h);
        end
        cycles(1);
        n_tests++;
        if ({tc_w, tc_h, running_w} !== 3'b001) begin
            n_fail++;
            $display("[TB] FAIL tc_width: got tc_w=%b tc_h=%b run=%b expected 0 0 1", tc_w, tc_h, running_w);
        end
        do_cmd(1, 0, 0, 4'd0);
        cycles(5);
        n_tests++;
        if ({thou_h, hund_h, tens_h, ones_h, running_h} !== {16'h9999, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL done_ignores_start: got %h run=%b expected 9999 0",
                     {thou_h, hund_h, tens_h, ones_h}, running_h);
        end
    endtask

    // Load clamp and down-count borrow through terminal count.
    task automatic test_terminal_down();
        apply_reset();
        do_cmd(0, 0, 1, 4'hC);
        n_tests++;
        if ({thou_w, hund_w, tens_w, ones_w} !== 16'h9999) begin
            n_fail++;
            $display("[TB] FAIL load_clamp: got %h expected 9999", {thou_w, hund_w, tens_w, ones_w});
        end
        do_cmd(0, 0, 1, 4'd0);
        up_dn = 1'b0;
        do_cmd(1, 0, 0, 4'd0);
        cycles(4);
        n_tests++;
        if ({thou_w, hund_w, tens_w, ones_w, tc_w, running_w} !== {16'h9999, 1'b1, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL wrap_down: got %h tc=%b run=%b expected 9999 1 1",
                     {thou_w, hund_w, tens_w, ones_w}, tc_w, running_w);
        end
        n_tests++;
        if ({thou_h, hund_h, tens_h, ones_h, tc_h, running_h} !== {16'h0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL hold_down: got %h tc=%b run=%b expected 0000 1 0",
                     {thou_h, hund_h, tens_h, ones_h}, tc_h, running_h);
        end
    endtask

    // Stop landing on a tick, pause hold, and resume latency.
    task automatic test_stop_on_tick();
        apply_reset();
        up_dn = 1'b1;
        do_cmd(1, 0, 0, 4'd0);
        cycles(76);
        n_tests++;
        if ({thou_w, hund_w, tens_w, ones_w} !== 16'h0019) begin
            n_fail++;
            $display("[TB] FAIL count19: got %h expected 0019", {thou_w, hund_w, tens_w, ones_w});
        end
        cycles(3);
        do_cmd(0, 1, 0, 4'd0);
        n_tests++;
        if ({thou_w, hund_w, tens_w, ones_w, running_w} !== {16'h0020, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL stop_tick: got %h run=%b expected 0020 0", {thou_w, hund_w, tens_w, ones_w}, running_w);
        end
        cycles(20);
        n_tests++;
        if ({thou_w, hund_w, tens_w, ones_w} !== 16'h0020) begin
            n_fail++;
            $display("[TB] FAIL pause_hold: got %h expected 0020", {thou_w, hund_w, tens_w, ones_w});
        end
        do_cmd(1, 0, 0, 4'd0);
        cycles(3);
        n_tests++;
        if ({thou_w, hund_w, tens_w, ones_w} !== 16'h0020) begin
            n_fail++;
            $display("[TB] FAIL resume_early: got %h expected 0020", {thou_w, hund_w, tens_w, ones_w});
        end
        cycles(1);
        n_tests++;
        if ({thou_w, hund_w, tens_w, ones_w} !== 16'h0021) begin
            n_fail++;
            $display("[TB] FAIL resume_tick: got %h expected 0021", {thou_w, hund_w, tens_w, ones_w});
        end
    endtask

    // Simultaneous commands in PAUSED, and load refused while running.
    task automatic test_cmd_priority();
        apply_reset();
        up_dn = 1'b1;
        do_cmd(0, 0, 1, 4'd5);
        do_cmd(1, 1, 1, 4'd3);
        n_tests++;
        if ({thou_w, hund_w, tens_w, ones_w, running_w} !== {16'h3333, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL all_cmds: got %h run=%b expected 3333 0", {thou_w, hund_w, tens_w, ones_w}, running_w);
        end
        do_cmd(1, 0, 0, 4'd0);
        do_cmd(0, 0, 1, 4'd7);
        n_tests++;
        if ({thou_w, hund_w, tens_w, ones_w, running_w} !== {16'h3333, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL load_in_run: got %h run=%b expected 3333 1", {thou_w, hund_w, tens_w, ones_w}, running_w);
        end
        cycles(3);
        n_tests++;
        if ({thou_w, hund_w, tens_w, ones_w} !== 16'h3334) begin
            n_fail++;
            $display("[TB] FAIL count_after_load: got %h expected 3334", {thou_w, hund_w, tens_w, ones_w});
        end
    endtask

    // Display of 0105 across all select slots, then reset while running.
    task automatic test_display_blank();
        logic [3:0] exp_an;
        logic [3:0] exp_dg;
        apply_reset();
        up_dn = 1'b1;
        do_cmd(1, 0, 0, 4'd0);
        cycles(420);
        do_cmd(0, 1, 0, 4'd0);
        n_tests++;
        if ({thou_w, hund_w, tens_w, ones_w} !== 16'h0105) begin
            n_fail++;
            $display("[TB] FAIL count105: got %h expected 0105", {thou_w, hund_w, tens_w, ones_w});
        end
        for (int k = 0; k < 8; k++) begin
            case (m_sel)
                0:       begin exp_an = 4'b1110; exp_dg = 4'd5; end
                1:       begin exp_an = 4'b1101; exp_dg = 4'd0; end
                2:       begin exp_an = 4'b1011; exp_dg = 4'd1; end
                default: begin exp_an = 4'b1111; exp_dg = 4'd0; end
            endcase
            n_tests++;
            if ({anode_w, digit_w} !== {exp_an, exp_dg}) begin
                n_fail++;
                $display("[TB] FAIL disp105 sel=%0d: got anode=%b digit=%h expected %b %h",
                         m_sel, anode_w, digit_w, exp_an, exp_dg);
            end
            cycles(1);
        end
        do_cmd(1, 0, 0, 4'd0);
        cycles(3);
        apply_reset();
        n_tests++;
        if ({thou_w, hund_w, tens_w, ones_w, running_w, tc_w} !== {16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_run: got %h run=%b tc=%b expected 0000 0 0",
                     {thou_w, hund_w, tens_w, ones_w}, running_w, tc_w);
        end
        cycles(8);
        n_tests++;
        if ({thou_w, hund_w, tens_w, ones_w, running_w} !== {16'h0000, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: got %h run=%b expected 0000 0",
                     {thou_w, hund_w, tens_w, ones_w}, running_w);
        end
    endtask

    // Random command/direction/data traffic checked every cycle on both copies.
    task automatic test_random();
        logic [25:0] exp_v;
        logic [25:0] got_v;
        int pick;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 19) == 0);
            load  = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 39) == 0) up_dn = ~up_dn;
            pick = $urandom_range(0, 2);
            data_in = (pick == 0) ? 4'd0 : (pick == 1) ? 4'd9 : 4'($urandom_range(0, 15));
            @(negedge clk);
            exp_v = model_out(0);
            got_v = {thou_w, hund_w, tens_w, ones_w, anode_w, digit_w, running_w, tc_w};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL random_wrap cycle %0d: got %h expected %h", c, got_v, exp_v);
            end
            exp_v = model_out(1);
            got_v = {thou_h, hund_h, tens_h, ones_h, anode_h, digit_h, running_h, tc_h};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL random_hold cycle %0d: got %h expected %h", c, got_v, exp_v);
            end
        end
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        load  = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        load    = 1'b0;
        data_in = 4'd0;
        up_dn   = 1'b1;
        test_reset();
        test_start_latency();
        test_terminal_up();
        test_terminal_down();
        test_stop_on_tick();
        test_cmd_priority();
        test_display_blank();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_count_ctrl.md
Name: bcd_count_ctrl

Overview:
Single-clock sequencer for a 4-digit BCD counter and its multiplexed 7-segment display. It replaces per-digit ripple clocks with a prescaled tick enable and a same-cycle synchronous carry/borrow chain. It accepts start/stop/load commands through a small FSM and drives digit select plus the BCD nibble feeding the segment decoder. It sits between the board switches and buttons and the existing BCD-to-segment converter.

Parameters:
TICK_DIV, 50000000, clk cycles per count tick (1 s at 50 MHz); must be >=2
SCAN_DIV, 50000, clk cycles per display digit slot; must be >=1
WRAP, 1, 1 = roll over at terminal count; 0 = stop in DONE

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle start/resume command
stop  in  1  single-cycle pause command
load  in  1  single-cycle load command
data_in  in  4  BCD value loaded into all four digits
up_dn  in  1  1 = count up, 0 = count down; sampled on each tick
ones  out  4  BCD digit 0
tens  out  4  BCD digit 1
hundreds  out  4  BCD digit 2
thousands  out  4  BCD digit 3
anode  out  4  active-low one-hot digit enable; 4'b1111 = blanked
digit  out  4  BCD value of the currently selected digit
running  out  1  high while FSM is in RUN
tc  out  1  one-cycle pulse on a terminal-count tick

Behaviour:
- One clock. Reset is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset has highest priority.
  - FSM = IDLE; all digits = 0; prescaler = 0; scan counter = 0; sel = 0.
  - Outputs after reset: running = 0, tc = 0, anode = 4'b1110, digit = 0.
- FSM states: IDLE, RUN, PAUSED, DONE.
  - IDLE/PAUSED: start -> RUN.
  - RUN: stop -> PAUSED.
  - IDLE/PAUSED/DONE: load -> PAUSED, with all digits = data_in.
  - DONE: start is ignored.
  - Commands not listed for a state have no effect. load is ignored in RUN.
- Same-cycle command priority: stop > load > start.
- data_in values 10..15 clamp to 9 on load.
- Prescaler:
  - Cleared to 0 on every entry to RUN; held in all other states.
  - In RUN it counts 0..TICK_DIV-1. tick = 1 in the cycle the count equals TICK_DIV-1, then it wraps to 0.
  - First increment therefore lands exactly TICK_DIV cycles after the edge that accepts start.
- Tick update:
  - All four digits update in the same edge.
  - Up: ones+1; a digit at 9 becomes 0 and carries to the next digit.
  - Down: a digit at 0 becomes 9 and borrows from the next digit.
- Terminal count: a tick with up at 9999, or down at 0000.
  - tc = 1 for exactly that cycle's following clock (registered pulse, 1 cycle).
  - WRAP=1: digits roll to 0000 (up) or 9999 (down); FSM stays in RUN.
  - WRAP=0: digits hold their value; FSM -> DONE; running drops on the same edge.
- stop coincident with tick: the increment is applied AND the FSM goes to PAUSED on the same edge.
- Digit scan:
  - Scan counter free-runs in every state, 0..SCAN_DIV-1.
  - sel (2 bit) advances 0 -> 1 -> 2 -> 3 -> 0 on wrap.
  - sel mapping: 0 = ones, 1 = tens, 2 = hundreds, 3 = thousands.
- anode and digit are combinational from sel and the digit registers.
  - anode = ~(1 << sel).
  - digit = the selected digit.
- Leading-zero blanking:
  - If sel > 0 and the selected digit and all higher digits are 0, anode = 4'b1111.
  - digit still reports 0 in that case.
  - ones is never blanked.
- Reset mid-RUN returns to IDLE/0000 on that edge; a pending tick is discarded.

Test Plan:
(Run with TICK_DIV=4, SCAN_DIV=2, WRAP=1 unless stated.)
1. Reset then start pulse -> running=1 next cycle; ones=1 exactly 4 cycles after the start edge; ones=2 after 8 cycles; anode cycles 1110, 1111, 1111, 1111 every 2 cycles (upper digits blanked).
2. load with data_in=9 in IDLE -> digits 9999, state PAUSED. Start, then one tick with up_dn=1 -> 0000, tc high 1 cycle, running stays 1. Repeat with WRAP=0 -> digits stay 9999, running=0, further start ignored.
3. load data_in=0, up_dn=0, start, one tick -> 9999 with tc pulse. Load 4'hC -> digits 9999 (clamp).
4. Running at 0019, stop asserted in the tick cycle -> digits 0020 and PAUSED; 20 more cycles -> still 0020. start -> next increment exactly 4 cycles later (0021).
5. In PAUSED, start+stop+load all in one cycle with data_in=3 -> digits 3333, state PAUSED. load during RUN -> ignored, counting continues.
6. At digits 0105: sel=2 -> anode=1011, digit=1; sel=1 -> anode=1101, digit=0 (not blanked); sel=3 -> anode=1111. reset mid-RUN -> 0000, IDLE, running=0 next cycle.
